// File: rtl/cardinal_pkg.sv
// rtl/cardinal_pkg.sv - cardinal ISA opcode/function constants, width codes, decode helper and control FSM states
package cardinal_pkg;

  // Primary opcodes (instruction bits [0:5])
  localparam logic [0:5] OP_R_ALU     = 6'b101010;
  localparam logic [0:5] OP_LOAD      = 6'b100000;
  localparam logic [0:5] OP_STORE     = 6'b100001;
  localparam logic [0:5] OP_BRANCH_EZ = 6'b100010;
  localparam logic [0:5] OP_BRANCH_NZ = 6'b100011;
  localparam logic [0:5] OP_NOP       = 6'b111100;

  // R_ALU function codes (instruction bits [26:31])
  localparam logic [0:5] F_VNOP   = 6'b000000;
  localparam logic [0:5] F_VAND   = 6'b000001;
  localparam logic [0:5] F_VOR    = 6'b000010;
  localparam logic [0:5] F_VXOR   = 6'b000011;
  localparam logic [0:5] F_VNOT   = 6'b000100;
  localparam logic [0:5] F_VMOV   = 6'b000101;
  localparam logic [0:5] F_VADD   = 6'b000110;
  localparam logic [0:5] F_VSUB   = 6'b000111;
  localparam logic [0:5] F_VMULEU = 6'b001000;
  localparam logic [0:5] F_VMULOU = 6'b001001;
  localparam logic [0:5] F_VSLL   = 6'b001010;
  localparam logic [0:5] F_VSRL   = 6'b001011;
  localparam logic [0:5] F_VSRA   = 6'b001100;
  localparam logic [0:5] F_VRTTH  = 6'b001101;
  localparam logic [0:5] F_VDIV   = 6'b001110;
  localparam logic [0:5] F_VMOD   = 6'b001111;
  localparam logic [0:5] F_VSQEU  = 6'b010000;
  localparam logic [0:5] F_VSQOU  = 6'b010001;
  localparam logic [0:5] F_VSQRT  = 6'b010010;

  // Element width codes (instruction bits [24:25])
  localparam logic [0:1] WW_BYTE   = 2'b00;
  localparam logic [0:1] WW_HALF   = 2'b01;
  localparam logic [0:1] WW_WORD   = 2'b10;
  localparam logic [0:1] WW_DOUBLE = 2'b11;

  // Control FSM states
  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_e;

  // Register usage of the instruction sitting in ID
  typedef struct packed {
    logic rd_ra;  // reads rA
    logic rd_rb;  // reads rB
    logic rd_rd;  // reads rD (store data, branch condition)
    logic wr;     // writes rD
    logic mc;     // multi-cycle ALU operation
    logic bez;    // branch if rD == 0
    logic bnz;    // branch if rD != 0
  } dec_t;

  // Classify an instruction by the registers it reads and writes
  function automatic dec_t decode(input logic [0:5] op, input logic [0:5] func);
    dec_t d;
    d = '0;
    case (op)
      OP_R_ALU: begin
        d.rd_ra = 1'b1;
        // Unary functions take only rA
        d.rd_rb = !(func inside {F_VNOT, F_VMOV, F_VRTTH, F_VSQEU, F_VSQOU, F_VSQRT});
        d.wr    = (func != F_VNOP);
        d.mc    = (func inside {F_VDIV, F_VMOD, F_VSQRT});
      end
      OP_LOAD: begin
        d.rd_ra = 1'b1;
        d.wr    = 1'b1;
      end
      OP_STORE: begin
        d.rd_ra = 1'b1;
        d.rd_rd = 1'b1;
      end
      OP_BRANCH_EZ: begin
        d.rd_rd = 1'b1;
        d.bez   = 1'b1;
      end
      OP_BRANCH_NZ: begin
        d.rd_rd = 1'b1;
        d.bnz   = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - two-slot in-flight destination tracker with RAW comparators; honours HAZ_R0_ZERO_EN
module hazard_scoreboard
  import cardinal_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_hold,
  input  logic       i_wr_en,
  input  logic [0:4] i_wr_rd,
  input  logic       i_ra_en,
  input  logic [0:4] i_ra,
  input  logic       i_rb_en,
  input  logic [0:4] i_rb,
  input  logic       i_rd_en,
  input  logic [0:4] i_rd,
  output logic       o_raw_hit
);

  logic       r_ex_v;
  logic [0:4] r_ex_rd;
  logic       r_wb_v;
  logic [0:4] r_wb_rd;

  logic w_ra_chk;
  logic w_rb_chk;
  logic w_rd_chk;
  logic w_wr_rec;

`ifdef HAZ_R0_ZERO_EN
  // r0 is constant zero: never a source of hazards, never worth recording
  assign w_ra_chk = i_ra_en && (i_ra != 5'd0);
  assign w_rb_chk = i_rb_en && (i_rb != 5'd0);
  assign w_rd_chk = i_rd_en && (i_rd != 5'd0);
  assign w_wr_rec = i_wr_en && (i_wr_rd != 5'd0);
`else
  assign w_ra_chk = i_ra_en;
  assign w_rb_chk = i_rb_en;
  assign w_rd_chk = i_rd_en;
  assign w_wr_rec = i_wr_en;
`endif

  // Compare every source read in ID against both in-flight destinations
  always_comb begin
    o_raw_hit = 1'b0;
    if (w_ra_chk && ((r_ex_v && (r_ex_rd == i_ra)) || (r_wb_v && (r_wb_rd == i_ra)))) o_raw_hit = 1'b1;
    if (w_rb_chk && ((r_ex_v && (r_ex_rd == i_rb)) || (r_wb_v && (r_wb_rd == i_rb)))) o_raw_hit = 1'b1;
    if (w_rd_chk && ((r_ex_v && (r_ex_rd == i_rd)) || (r_wb_v && (r_wb_rd == i_rd)))) o_raw_hit = 1'b1;
  end

  // Slots shadow ID_EX and EX_MEM; a hold freezes EX while EX_MEM drains to a bubble
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ex_v  <= 1'b0;
      r_ex_rd <= '0;
      r_wb_v  <= 1'b0;
      r_wb_rd <= '0;
    end else if (i_hold) begin
      r_wb_v  <= 1'b0;
    end else begin
      r_wb_v  <= r_ex_v;
      r_wb_rd <= r_ex_rd;
      r_ex_v  <= w_wr_rec;
      r_ex_rd <= i_wr_rd;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - cardinal pipeline stall/flush/branch/multi-cycle control; optional HAZ_R0_ZERO_EN
module pipeline_hazard_ctrl
  import cardinal_pkg::*;
#(
  parameter int unsigned MC_TIMEOUT = 64
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_id_valid,
  input  logic [0:5] i_id_op,
  input  logic [0:4] i_id_rd,
  input  logic [0:4] i_id_ra,
  input  logic [0:4] i_id_rb,
  input  logic [0:5] i_id_func,
  input  logic       i_id_rd_zero,
  input  logic       i_mc_done,
  output logic       o_pc_we,
  output logic       o_if_id_we,
  output logic       o_if_id_flush,
  output logic       o_id_ex_bubble,
  output logic       o_ex_hold,
  output logic       o_br_taken,
  output logic       o_mc_start,
  output logic       o_mc_timeout
);

  localparam int unsigned    CW       = $clog2(MC_TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(MC_TIMEOUT - 1);

  state_e        r_state;
  state_e        w_next;
  logic [CW-1:0] r_cnt;
  logic          r_mc_start;

  dec_t          w_dec;
  logic          w_raw_hit;
  logic          w_eval;
  logic          w_issue;
  logic          w_taken;
  logic          w_cnt_hit;
  logic          w_wr_en;

  // Flushed IF_ID contents use no registers at all
  always_comb begin
    w_dec = '0;
    if (i_id_valid) w_dec = decode(i_id_op, i_id_func);
  end

  assign w_taken   = (w_dec.bez && i_id_rd_zero) || (w_dec.bnz && !i_id_rd_zero);
  // r_cnt counts MC_WAIT cycles already spent, so this is the MC_TIMEOUT-th one
  assign w_cnt_hit = (r_cnt == CNT_LAST);
  assign w_wr_en   = w_issue && w_dec.wr;

  hazard_scoreboard u_scoreboard (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_hold    (o_ex_hold),
    .i_wr_en   (w_wr_en),
    .i_wr_rd   (i_id_rd),
    .i_ra_en   (w_dec.rd_ra),
    .i_ra      (i_id_ra),
    .i_rb_en   (w_dec.rd_rb),
    .i_rb      (i_id_rb),
    .i_rd_en   (w_dec.rd_rd),
    .i_rd      (i_id_rd),
    .o_raw_hit (w_raw_hit)
  );

  // Next state and pipeline enables; a release cycle decides ID exactly like RUN
  always_comb begin
    w_next         = r_state;
    w_eval         = 1'b0;
    w_issue        = 1'b0;
    o_pc_we        = 1'b0;
    o_if_id_we     = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    o_ex_hold      = 1'b0;
    o_br_taken     = 1'b0;
    o_mc_timeout   = 1'b0;

    case (r_state)
      RUN: w_eval = 1'b1;
      MC_WAIT: begin
        if (i_mc_done) begin
          w_eval = 1'b1;
        end else if (w_cnt_hit) begin
          w_eval       = 1'b1;
          o_mc_timeout = 1'b1;
        end else begin
          o_ex_hold = 1'b1;
        end
      end
      default: w_next = RUN;
    endcase

    if (w_eval) begin
      w_next = RUN;
      if (w_raw_hit) begin
        // Stall wins over branch resolution: the branch may be waiting on its own rD
        o_id_ex_bubble = 1'b1;
      end else begin
        w_issue    = 1'b1;
        o_pc_we    = 1'b1;
        o_if_id_we = 1'b1;
        if (w_taken) begin
          o_br_taken    = 1'b1;
          o_if_id_flush = 1'b1;
        end
        if (w_dec.mc) w_next = MC_WAIT;
      end
    end

    // Outputs take their quiescent values for the whole time reset is held
    if (!i_rst_n) begin
      w_next         = RUN;
      w_issue        = 1'b0;
      o_pc_we        = 1'b0;
      o_if_id_we     = 1'b0;
      o_if_id_flush  = 1'b1;
      o_id_ex_bubble = 1'b1;
      o_ex_hold      = 1'b0;
      o_br_taken     = 1'b0;
      o_mc_timeout   = 1'b0;
    end
  end

  // State register, MC_WAIT cycle counter and the registered start pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= RUN;
      r_cnt      <= '0;
      r_mc_start <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= o_ex_hold ? (r_cnt + CW'(1)) : '0;
      r_mc_start <= w_issue && w_dec.mc;
    end
  end

  assign o_mc_start = r_mc_start;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed and randomized check of pipeline_hazard_ctrl against a reference model
module tb_pipeline_hazard_ctrl;

  localparam int TMO = 8;

  localparam logic [5:0] OP_ALU = 6'b101010;
  localparam logic [5:0] OP_LD  = 6'b100000;
  localparam logic [5:0] OP_ST  = 6'b100001;
  localparam logic [5:0] OP_BEZ = 6'b100010;
  localparam logic [5:0] OP_BNZ = 6'b100011;
  localparam logic [5:0] OP_NOP = 6'b111100;
  localparam logic [5:0] OP_UNK = 6'b000111;

  localparam logic [5:0] F_VNOP  = 6'd0;
  localparam logic [5:0] F_VAND  = 6'd1;
  localparam logic [5:0] F_VNOT  = 6'd4;
  localparam logic [5:0] F_VMOV  = 6'd5;
  localparam logic [5:0] F_VADD  = 6'd6;
  localparam logic [5:0] F_VRTTH = 6'd13;
  localparam logic [5:0] F_VDIV  = 6'd14;
  localparam logic [5:0] F_VMOD  = 6'd15;
  localparam logic [5:0] F_VSQEU = 6'd16;
  localparam logic [5:0] F_VSQOU = 6'd17;
  localparam logic [5:0] F_VSQRT = 6'd18;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [0:5] id_op;
  logic [0:4] id_rd;
  logic [0:4] id_ra;
  logic [0:4] id_rb;
  logic [0:5] id_func;
  logic       id_rd_zero;
  logic       mc_done;
  logic       o_pc_we, o_if_id_we, o_if_id_flush, o_id_ex_bubble;
  logic       o_ex_hold, o_br_taken, o_mc_start, o_mc_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: cycles until each register's pending write retires, MC bookkeeping
  int busy [32];
  bit m_mc;
  int m_wait;
  bit m_start;

  pipeline_hazard_ctrl #(.MC_TIMEOUT(TMO)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_id_valid     (id_valid),
    .i_id_op        (id_op),
    .i_id_rd        (id_rd),
    .i_id_ra        (id_ra),
    .i_id_rb        (id_rb),
    .i_id_func      (id_func),
    .i_id_rd_zero   (id_rd_zero),
    .i_mc_done      (mc_done),
    .o_pc_we        (o_pc_we),
    .o_if_id_we     (o_if_id_we),
    .o_if_id_flush  (o_if_id_flush),
    .o_id_ex_bubble (o_id_ex_bubble),
    .o_ex_hold      (o_ex_hold),
    .o_br_taken     (o_br_taken),
    .o_mc_start     (o_mc_start),
    .o_mc_timeout   (o_mc_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void spec_decode(input logic [5:0] op, input logic [5:0] func,
                                      output bit ra, output bit rb, output bit rd,
                                      output bit wr, output bit mc);
    ra = 0; rb = 0; rd = 0; wr = 0; mc = 0;
    case (op)
      OP_ALU: begin
        ra = 1;
        rb = !(func inside {F_VNOT, F_VMOV, F_VRTTH, F_VSQEU, F_VSQOU, F_VSQRT});
        wr = (func != F_VNOP);
        mc = (func inside {F_VDIV, F_VMOD, F_VSQRT});
      end
      OP_LD:         begin ra = 1; wr = 1; end
      OP_ST:         begin ra = 1; rd = 1; end
      OP_BEZ, OP_BNZ: rd = 1;
      default: ;
    endcase
  endfunction

  function automatic bit reg_busy(input logic [4:0] r);
`ifdef HAZ_R0_ZERO_EN
    if (r == 5'd0) return 1'b0;
`endif
    return busy[r] > 0;
  endfunction

  function automatic bit reg_tracked(input logic [4:0] r);
`ifdef HAZ_R0_ZERO_EN
    return r != 5'd0;
`else
    return r == r;
`endif
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) busy[r] = 0;
    m_mc = 0;
    m_wait = 0;
    m_start = 0;
  endtask

  task automatic chk_rst(input string tag);
    logic [7:0] obs;
    obs = {o_pc_we, o_if_id_we, o_if_id_flush, o_id_ex_bubble, o_ex_hold, o_br_taken, o_mc_start, o_mc_timeout};
    n_tests++;
    assert (obs === 8'b0011_0000) else begin
      n_fail++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, 8'b0011_0000);
    end
  endtask

  task automatic rst_pulse(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_rst(tag);
    @(negedge clk);
    #1;
    chk_rst(tag);
    model_reset();
    id_valid = 1'b0;
    mc_done  = 1'b0;
    rst_n    = 1'b1;
  endtask

  // One clock: drive ID, compare {pc,ifid,flush,bubble,hold,br,start,timeout}, advance the model
  task automatic cyc(input string tag, input bit v, input logic [5:0] op,
                     input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb,
                     input logic [5:0] func, input bit rdz, input bit done, output bit adv);
    bit e_ra, e_rb, e_rd, e_wr, e_mc;
    bit haz, taken, eval, hold, tmo, iss;
    logic [7:0] exp_v, obs_v;
    @(negedge clk);
    id_valid = v; id_op = op; id_rd = rd; id_ra = ra; id_rb = rb;
    id_func = func; id_rd_zero = rdz; mc_done = done;
    #1;
    spec_decode(op, func, e_ra, e_rb, e_rd, e_wr, e_mc);
    if (!v) begin e_ra = 0; e_rb = 0; e_rd = 0; e_wr = 0; e_mc = 0; end
    haz   = (e_ra && reg_busy(ra)) || (e_rb && reg_busy(rb)) || (e_rd && reg_busy(rd));
    taken = v && ((op == OP_BEZ && rdz) || (op == OP_BNZ && !rdz));
    eval = 0; hold = 0; tmo = 0;
    if (!m_mc || done) eval = 1;
    else if (m_wait + 1 == TMO) begin eval = 1; tmo = 1; end
    else hold = 1;
    iss = eval && !haz;
    exp_v = {iss, iss, iss && taken, eval && haz, hold, iss && taken, m_start, tmo};
    obs_v = {o_pc_we, o_if_id_we, o_if_id_flush, o_id_ex_bubble, o_ex_hold, o_br_taken, o_mc_start, o_mc_timeout};
    n_tests++;
    assert (obs_v === exp_v) else begin
      n_fail++;
      $error("FAIL %s (check %0d): observed %b, expected %b", tag, n_tests, obs_v, exp_v);
    end
    if (hold) begin
      for (int r = 0; r < 32; r++) if (busy[r] == 1) busy[r] = 0;
      m_wait++;
    end else begin
      for (int r = 0; r < 32; r++) if (busy[r] > 0) busy[r]--;
      if (iss && e_wr && reg_tracked(rd)) busy[rd] = 2;
      m_mc   = iss && e_mc;
      m_wait = 0;
    end
    m_start = iss && e_mc;
    adv = iss;
  endtask

  initial begin
    bit adv;
    bit c_v;
    logic [5:0] c_op, c_func;
    logic [4:0] c_rd, c_ra, c_rb;
    int k;

    rst_n = 1'b0; id_valid = 1'b0; id_op = '0; id_rd = '0; id_ra = '0; id_rb = '0;
    id_func = '0; id_rd_zero = 1'b0; mc_done = 1'b0;
    rst_pulse("reset_init");

    // RAW with writer directly ahead: two stalls then issue
    cyc("raw_vadd_r3",  1, OP_ALU, 3, 1, 2, F_VADD, 0, 0, adv);
    for (int i = 0; i < 3; i++) cyc("raw_vand_r3", 1, OP_ALU, 4, 3, 1, F_VAND, 0, 0, adv);
    cyc("raw_nop", 1, OP_NOP, 0, 0, 0, F_VNOP, 0, 0, adv);
    cyc("raw_nop", 0, OP_NOP, 0, 0, 0, F_VNOP, 0, 0, adv);

    // Branches on a clean register
    cyc("bez_taken",    1, OP_BEZ, 1, 0, 0, F_VNOP, 1, 0, adv);
    cyc("bez_flushed",  0, OP_NOP, 0, 0, 0, F_VNOP, 0, 0, adv);
    cyc("bez_not_taken", 1, OP_BEZ, 1, 0, 0, F_VNOP, 0, 0, adv);
    cyc("bnz_not_taken", 1, OP_BNZ, 2, 0, 0, F_VNOP, 1, 0, adv);

    // LOAD r5 then BNEZ r5: stalled twice, taken in the third cycle
    cyc("ld_r5", 1, OP_LD, 5, 1, 0, F_VNOP, 0, 0, adv);
    for (int i = 0; i < 3; i++) cyc("bnz_r5", 1, OP_BNZ, 5, 0, 0, F_VNOP, 0, 0, adv);
    cyc("bnz_flushed", 0, OP_NOP, 0, 0, 0, F_VNOP, 0, 0, adv);

    // VDIV with mc_done on the fifth MC_WAIT cycle
    cyc("vdiv_issue", 1, OP_ALU, 6, 1, 2, F_VDIV, 0, 0, adv);
    for (int i = 0; i < 4; i++) cyc("vdiv_wait", 1, OP_ALU, 7, 1, 2, F_VADD, 0, 0, adv);
    cyc("vdiv_done", 1, OP_ALU, 7, 1, 2, F_VADD, 0, 1, adv);
    cyc("after_vdiv", 1, OP_NOP, 0, 0, 0, F_VNOP, 0, 0, adv);
    cyc("after_vdiv", 1, OP_NOP, 0, 0, 0, F_VNOP, 0, 0, adv);

    // mc_done coincident with mc_start
    cyc("vmod_issue", 1, OP_ALU, 9, 1, 2, F_VMOD, 0, 0, adv);
    cyc("vmod_done1", 1, OP_ALU, 10, 9, 1, F_VADD, 0, 1, adv);
    cyc("vmod_dep",   1, OP_ALU, 10, 9, 1, F_VADD, 0, 0, adv);
    cyc("vmod_dep",   1, OP_ALU, 10, 9, 1, F_VADD, 0, 0, adv);

    // Timeout: consumer of the VSQRT result released by the forced timeout
    cyc("vsqrt_issue", 1, OP_ALU, 6, 1, 0, F_VSQRT, 0, 0, adv);
    for (int i = 0; i < TMO; i++) cyc("vsqrt_wait", 1, OP_ALU, 8, 6, 1, F_VADD, 0, 0, adv);
    for (int i = 0; i < 2; i++) cyc("vsqrt_dep", 1, OP_ALU, 8, 6, 1, F_VADD, 0, 0, adv);

    // Reset in the middle of MC_WAIT
    cyc("vdiv_issue2", 1, OP_ALU, 11, 1, 2, F_VDIV, 0, 0, adv);
    for (int i = 0; i < 3; i++) cyc("vdiv_wait2", 1, OP_NOP, 0, 0, 0, F_VNOP, 0, 0, adv);
    rst_pulse("reset_mid_wait");
    cyc("post_reset", 1, OP_NOP, 0, 0, 0, F_VNOP, 0, 1, adv);
    cyc("post_reset", 1, OP_NOP, 0, 0, 0, F_VNOP, 0, 0, adv);

    // Write to r0 then read r0
    cyc("r0_write", 1, OP_ALU, 0, 1, 2, F_VADD, 0, 0, adv);
    for (int i = 0; i < 3; i++) cyc("r0_read", 1, OP_ALU, 4, 0, 1, F_VAND, 0, 0, adv);

    // Randomized instruction stream; ID holds its instruction until it issues
    adv = 1;
    c_v = 0; c_op = OP_NOP; c_func = F_VNOP; c_rd = '0; c_ra = '0; c_rb = '0;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        rst_pulse("reset_rand");
        adv = 1;
      end
      if (adv) begin
        c_v = ($urandom_range(0, 7) != 0);
        k = int'($urandom_range(0, 9));
        case (k)
          0, 1, 2, 3, 4: c_op = OP_ALU;
          5:             c_op = OP_LD;
          6:             c_op = OP_ST;
          7:             c_op = OP_BEZ;
          8:             c_op = OP_BNZ;
          default:       c_op = ($urandom_range(0, 1) != 0) ? OP_NOP : OP_UNK;
        endcase
        case ($urandom_range(0, 10))
          0:       c_func = F_VNOP;
          1:       c_func = F_VAND;
          2:       c_func = F_VNOT;
          3:       c_func = F_VMOV;
          4:       c_func = F_VRTTH;
          5:       c_func = F_VDIV;
          6:       c_func = F_VMOD;
          7:       c_func = F_VSQEU;
          8:       c_func = F_VSQOU;
          9:       c_func = F_VSQRT;
          default: c_func = F_VADD;
        endcase
        c_rd = 5'($urandom_range(0, 3));
        c_ra = 5'($urandom_range(0, 3));
        c_rb = 5'($urandom_range(0, 3));
      end
      cyc("random", c_v, c_op, c_rd, c_ra, c_rb, c_func,
          1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), adv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
